// File: rtl/draw_win_overlay_pkg.sv
// Shared constants for the end-of-game overlay: FSM states, winner encoding,
// sprite codes, overlay colours and the per-channel alpha blend.
package draw_win_overlay_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FADE = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_W    = 2'd1,
    WIN_B    = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

  localparam logic [1:0] CODE_CLEAR   = 2'd0;
  localparam logic [1:0] CODE_OUTLINE = 2'd1;
  localparam logic [1:0] CODE_FILL    = 2'd2;
  localparam logic [1:0] CODE_ACCENT  = 2'd3;

  localparam logic [11:0] OUTLINE_RGB   = 12'h666;
  localparam logic [11:0] FILL_W_RGB    = 12'hfff;
  localparam logic [11:0] FILL_B_RGB    = 12'h000;
  localparam logic [11:0] FILL_DRAW_RGB = 12'h888;
  localparam logic [11:0] ACCENT_RGB    = 12'hfc0;

  localparam logic [4:0] ALPHA_MAX = 5'd16;

  // Weights sum to 16, so the 9-bit sum never exceeds 240 and >>4 fits a nibble.
  function automatic logic [3:0] blendChannel(input logic [3:0] bg, input logic [3:0] fg,
                                              input logic [4:0] alpha);
    logic [8:0] sum;
    sum = 9'(bg) * 9'(ALPHA_MAX - alpha) + 9'(fg) * 9'(alpha);
    return 4'(sum >> 4);
  endfunction

endpackage

// File: rtl/draw_win_overlay_rom.sv
// Trophy sprite, 2 bits per cell, registered read so the code lines up with
// pipeline stage 1 of the overlay.
module draw_win_overlay_rom
  import draw_win_overlay_pkg::*;
#(
  parameter int SPR_W = 20,
  parameter int SPR_H = 23,
  parameter int ROW_W = 5,
  parameter int COL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic [1:0]       o_code
);

  logic [39:0] w_masks;
  logic [5:0]  w_bitIdx;
  logic [1:0]  w_code;

  // Each row is {outline mask, fill mask}, column 0 at the MSB; accent cells set both.
  function automatic logic [39:0] rowMasks(input int row);
    case (row)
      0:               return {20'b00011111111111111000, 20'b00000000000000000000};
      1, 7:            return {20'b00010000000000001000, 20'b00001111111111110000};
      2, 6:            return {20'b11110000000000001111, 20'b00001111111111110000};
      3:               return {20'b10010000000000001001, 20'b00001111111111110000};
      4, 5:            return {20'b10010000110000001001, 20'b00001111111111110000};
      8, 20, 21:       return {20'b00001000000000010000, 20'b00000111111111100000};
      9, 18, 19:       return {20'b00000100000000100000, 20'b00000011111111000000};
      10, 16:          return {20'b00000010000001000000, 20'b00000001111110000000};
      11, 15:          return {20'b00000001000010000000, 20'b00000000111100000000};
      12, 13, 14:      return {20'b00000000100100000000, 20'b00000000011000000000};
      17:              return {20'b00000111111111100000, 20'b00000000000000000000};
      22:              return {20'b00001111111111110000, 20'b00000000000000000000};
      default:         return 40'd0;
    endcase
  endfunction

  always_comb begin
    w_masks  = rowMasks(int'(i_row));
    w_bitIdx = 6'd0;
    w_code   = CODE_CLEAR;
    if (int'(i_row) < SPR_H && int'(i_col) < SPR_W && int'(i_col) < 20) begin
      w_bitIdx = 6'(19 - int'(i_col));
      w_code   = {w_masks[w_bitIdx], w_masks[6'd20 + w_bitIdx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) o_code <= CODE_CLEAR;
    else     o_code <= w_code;
  end

endmodule

// File: rtl/draw_win_overlay.sv
// End-of-game overlay: latches the result, fades a trophy sprite and backdrop in
// over the live VGA stream with a fixed 2-cycle latency, and holds it until new_game.
module draw_win_overlay
  import draw_win_overlay_pkg::*;
#(
  parameter int          X0        = 272,
  parameter int          Y0        = 116,
  parameter int          CELL      = 24,
  parameter int          SPR_W     = 20,
  parameter int          SPR_H     = 23,
  parameter int          FADE_STEP = 1,
  parameter logic [11:0] BG_RGB    = 12'h0f0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_white_win,
  input  logic        i_black_win,
  input  logic        i_new_game,
  input  logic [10:0] i_vga_hcount,
  input  logic [10:0] i_vga_vcount,
  input  logic        i_vga_hsync,
  input  logic        i_vga_vsync,
  input  logic        i_vga_hblnk,
  input  logic        i_vga_vblnk,
  input  logic [11:0] i_vga_rgb,
  output logic [10:0] o_vga_hcount,
  output logic [10:0] o_vga_vcount,
  output logic        o_vga_hsync,
  output logic        o_vga_vsync,
  output logic        o_vga_hblnk,
  output logic        o_vga_vblnk,
  output logic [11:0] o_vga_rgb,
  output logic        o_shown
);

  localparam int COL_W = $clog2(SPR_W > 1 ? SPR_W : 2);
  localparam int ROW_W = $clog2(SPR_H > 1 ? SPR_H : 2);

  logic [1:0]  r_state;
  logic [4:0]  r_alpha;
  winner_t     r_winner;
  logic        r_prevVblnk;
  logic        w_frameTick;
  logic [5:0]  w_alphaSum;
  logic [4:0]  w_alphaNext;

  logic [10:0] r_prevH, r_prevV, r_col, r_row, r_subX, r_subY;
  logic [10:0] w_col, w_row, w_subX, w_subY;
  logic        w_inSpr;
  logic [1:0]  w_code;

  logic [10:0] r_s1Hcount, r_s1Vcount;
  logic        r_s1Hsync, r_s1Vsync, r_s1Hblnk, r_s1Vblnk, r_s1InSpr;
  logic [11:0] r_s1Rgb;
  logic [11:0] w_fg, w_blend, w_rgbOut;

  assign w_frameTick = i_vga_vblnk & ~r_prevVblnk;
  assign w_alphaSum  = {1'b0, r_alpha} + 6'(FADE_STEP);
  assign w_alphaNext = (w_alphaSum >= 6'(ALPHA_MAX)) ? ALPHA_MAX : w_alphaSum[4:0];
  assign o_shown     = (r_state == ST_SHOW);

  // new_game wins over everything; alpha only moves on frame boundaries to avoid tearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_alpha     <= 5'd0;
      r_winner    <= WIN_NONE;
      r_prevVblnk <= 1'b0;
    end else begin
      r_prevVblnk <= i_vga_vblnk;
      if (i_new_game) begin
        r_state  <= ST_IDLE;
        r_alpha  <= 5'd0;
        r_winner <= WIN_NONE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_white_win || i_black_win) begin
              r_state <= ST_FADE;
              if (i_white_win && i_black_win) r_winner <= WIN_DRAW;
              else if (i_white_win)           r_winner <= WIN_W;
              else                            r_winner <= WIN_B;
            end
          end
          ST_FADE: begin
            if (w_frameTick) begin
              r_alpha <= w_alphaNext;
              if (w_alphaNext == ALPHA_MAX) r_state <= ST_SHOW;
            end
          end
          ST_SHOW: r_alpha <= ALPHA_MAX;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Cell position tracks the pixel stream instead of dividing: restart at the
  // sprite origin, advance whenever the coordinate moves, roll over every CELL pixels.
  always_comb begin
    w_col  = r_col;
    w_subX = r_subX;
    if (i_vga_hcount == 11'(X0)) begin
      w_col  = 11'd0;
      w_subX = 11'd0;
    end else if (i_vga_hcount != r_prevH) begin
      if (r_subX == 11'(CELL - 1)) begin
        w_col  = r_col + 11'd1;
        w_subX = 11'd0;
      end else begin
        w_subX = r_subX + 11'd1;
      end
    end
    w_row  = r_row;
    w_subY = r_subY;
    if (i_vga_vcount == 11'(Y0)) begin
      w_row  = 11'd0;
      w_subY = 11'd0;
    end else if (i_vga_vcount != r_prevV) begin
      if (r_subY == 11'(CELL - 1)) begin
        w_row  = r_row + 11'd1;
        w_subY = 11'd0;
      end else begin
        w_subY = r_subY + 11'd1;
      end
    end
  end

  assign w_inSpr = (int'(i_vga_hcount) >= X0) && (int'(i_vga_hcount) < X0 + SPR_W * CELL) &&
                   (int'(i_vga_vcount) >= Y0) && (int'(i_vga_vcount) < Y0 + SPR_H * CELL) &&
                   (i_vga_hcount < 11'd1024) && (i_vga_vcount < 11'd768);

  draw_win_overlay_rom #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .i_row (w_row[ROW_W-1:0]),
    .i_col (w_col[COL_W-1:0]),
    .o_code(w_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prevH    <= 11'd0;
      r_prevV    <= 11'd0;
      r_col      <= 11'd0;
      r_row      <= 11'd0;
      r_subX     <= 11'd0;
      r_subY     <= 11'd0;
      r_s1Hcount <= 11'd0;
      r_s1Vcount <= 11'd0;
      r_s1Hsync  <= 1'b0;
      r_s1Vsync  <= 1'b0;
      r_s1Hblnk  <= 1'b0;
      r_s1Vblnk  <= 1'b0;
      r_s1Rgb    <= 12'h000;
      r_s1InSpr  <= 1'b0;
    end else begin
      r_prevH    <= i_vga_hcount;
      r_prevV    <= i_vga_vcount;
      r_col      <= w_col;
      r_row      <= w_row;
      r_subX     <= w_subX;
      r_subY     <= w_subY;
      r_s1Hcount <= i_vga_hcount;
      r_s1Vcount <= i_vga_vcount;
      r_s1Hsync  <= i_vga_hsync;
      r_s1Vsync  <= i_vga_vsync;
      r_s1Hblnk  <= i_vga_hblnk;
      r_s1Vblnk  <= i_vga_vblnk;
      r_s1Rgb    <= i_vga_rgb;
      r_s1InSpr  <= w_inSpr;
    end
  end

  always_comb begin
    w_fg = BG_RGB;
    if (r_s1InSpr) begin
      case (w_code)
        CODE_OUTLINE: w_fg = OUTLINE_RGB;
        CODE_FILL: begin
          case (r_winner)
            WIN_W:   w_fg = FILL_W_RGB;
            WIN_B:   w_fg = FILL_B_RGB;
            default: w_fg = FILL_DRAW_RGB;
          endcase
        end
        CODE_ACCENT: w_fg = (r_winner == WIN_DRAW) ? OUTLINE_RGB : ACCENT_RGB;
        default:     w_fg = BG_RGB;
      endcase
    end
    w_blend = {blendChannel(r_s1Rgb[11:8], w_fg[11:8], r_alpha),
               blendChannel(r_s1Rgb[7:4],  w_fg[7:4],  r_alpha),
               blendChannel(r_s1Rgb[3:0],  w_fg[3:0],  r_alpha)};
    // IDLE bypasses the blender so pass-through is bit-exact by construction.
    if (r_state == ST_IDLE)            w_rgbOut = r_s1Rgb;
    else if (r_s1Hblnk || r_s1Vblnk)   w_rgbOut = 12'h000;
    else                               w_rgbOut = w_blend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vga_hcount <= 11'd0;
      o_vga_vcount <= 11'd0;
      o_vga_hsync  <= 1'b0;
      o_vga_vsync  <= 1'b0;
      o_vga_hblnk  <= 1'b0;
      o_vga_vblnk  <= 1'b0;
      o_vga_rgb    <= 12'h000;
    end else begin
      o_vga_hcount <= r_s1Hcount;
      o_vga_vcount <= r_s1Vcount;
      o_vga_hsync  <= r_s1Hsync;
      o_vga_vsync  <= r_s1Vsync;
      o_vga_hblnk  <= r_s1Hblnk;
      o_vga_vblnk  <= r_s1Vblnk;
      o_vga_rgb    <= w_rgbOut;
    end
  end

endmodule

// File: tb/tb_draw_win_overlay.sv
// Directed bench for draw_win_overlay: reset, exact pass-through latency, fade
// ramp, per-winner colours, cell edges, new_game priority and reset mid-fade.
module tb_draw_win_overlay;

  localparam int X0 = 272;
  localparam int Y0 = 116;

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        blank;
    logic [11:0] exp;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        whiteWin, blackWin, newGame;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk;
  logic [11:0] rgbIn;
  logic [10:0] hcountOut, vcountOut;
  logic        hsyncOut, vsyncOut, hblnkOut, vblnkOut;
  logic [11:0] rgbOut;
  logic        shown;
  logic [37:0] outPacked;
  logic [37:0] hist [0:19];

  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs [16];

  always #5 clk = ~clk;

  assign outPacked = {hcountOut, vcountOut, hsyncOut, vsyncOut, hblnkOut, vblnkOut, rgbOut};

  draw_win_overlay #(
    .FADE_STEP(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_white_win (whiteWin),
    .i_black_win (blackWin),
    .i_new_game  (newGame),
    .i_vga_hcount(hcount),
    .i_vga_vcount(vcount),
    .i_vga_hsync (hsync),
    .i_vga_vsync (vsync),
    .i_vga_hblnk (hblnk),
    .i_vga_vblnk (vblnk),
    .i_vga_rgb   (rgbIn),
    .o_vga_hcount(hcountOut),
    .o_vga_vcount(vcountOut),
    .o_vga_hsync (hsyncOut),
    .o_vga_vsync (vsyncOut),
    .o_vga_hblnk (hblnkOut),
    .o_vga_vblnk (vblnkOut),
    .o_vga_rgb   (rgbOut),
    .o_shown     (shown)
  );

  task automatic checkOutput(input string name, input logic [37:0] act, input logic [37:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic randomInputs();
    hcount = 11'($urandom);
    vcount = 11'($urandom);
    hsync  = 1'($urandom);
    vsync  = 1'($urandom);
    hblnk  = 1'($urandom);
    vblnk  = 1'($urandom);
    rgbIn  = 12'($urandom);
  endtask

  // Walks the stream up to (h,v) so the cell counters see a continuous scan, then
  // holds the pixel until its result reaches the output register.
  task automatic applyStimulus(input int h, input int v, input logic [11:0] rgb, input logic blank);
    int vs;
    int hs;
    hblnk  = 1'b0;
    vblnk  = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    rgbIn  = rgb;
    hcount = 11'd0;
    vs = (v >= Y0) ? Y0 - 1 : v;
    for (int y = vs; y <= v; y++) begin
      vcount = 11'(y);
      @(negedge clk);
    end
    hs = (h >= X0) ? X0 - 1 : h;
    for (int x = hs; x <= h; x++) begin
      hcount = 11'(x);
      @(negedge clk);
    end
    hblnk = blank;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic frameTick();
    vblnk = 1'b1;
    @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic w, input logic b, input logic n);
    whiteWin = w;
    blackWin = b;
    newGame  = n;
    @(negedge clk);
    whiteWin = 1'b0;
    blackWin = 1'b0;
    newGame  = 1'b0;
  endtask

  task automatic checkPixel(input string name, input int h, input int v, input logic [11:0] rgb,
                            input logic blank, input logic [11:0] exp);
    applyStimulus(h, v, rgb, blank);
    checkOutput(name, 38'(rgbOut), 38'(exp));
  endtask

  initial begin
    vecs[0]  = '{500, 400, 12'h123, 1'b0, 12'hfff, "w_fill"};
    vecs[1]  = '{10,  10,  12'h000, 1'b0, 12'h0f0, "w_outside"};
    vecs[2]  = '{271, 188, 12'h000, 1'b0, 12'h0f0, "edge_x0m1"};
    vecs[3]  = '{272, 188, 12'h000, 1'b0, 12'h666, "edge_x0"};
    vecs[4]  = '{295, 188, 12'h000, 1'b0, 12'h666, "edge_x0_cell_end"};
    vecs[5]  = '{296, 188, 12'h000, 1'b0, 12'h0f0, "edge_cell1"};
    vecs[6]  = '{464, 212, 12'h000, 1'b0, 12'hfc0, "w_accent"};
    vecs[7]  = '{500, 400, 12'h123, 1'b1, 12'h000, "w_blank"};
    vecs[8]  = '{344, 115, 12'h000, 1'b0, 12'h0f0, "edge_y0m1"};
    vecs[9]  = '{344, 116, 12'h000, 1'b0, 12'h666, "edge_y0"};
    vecs[10] = '{368, 139, 12'h000, 1'b0, 12'h666, "edge_row0_end"};
    vecs[11] = '{368, 140, 12'h000, 1'b0, 12'hfff, "edge_row1"};
    vecs[12] = '{368, 667, 12'h000, 1'b0, 12'h666, "edge_last_row"};
    vecs[13] = '{368, 668, 12'h000, 1'b0, 12'h0f0, "edge_below"};
    vecs[14] = '{751, 164, 12'h000, 1'b0, 12'h666, "edge_last_col"};
    vecs[15] = '{752, 164, 12'h000, 1'b0, 12'h0f0, "edge_right"};

    rst      = 1'b1;
    whiteWin = 1'b0;
    blackWin = 1'b0;
    newGame  = 1'b0;
    randomInputs();

    // Reset holds every output at zero regardless of the incoming stream.
    for (int i = 0; i < 5; i++) begin
      randomInputs();
      @(negedge clk);
      checkOutput($sformatf("reset_out_%0d", i), outPacked, 38'd0);
      checkOutput($sformatf("reset_shown_%0d", i), 38'(shown), 38'd0);
    end

    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      randomInputs();
      hist[k] = {hcount, vcount, hsync, vsync, hblnk, vblnk, rgbIn};
      @(negedge clk);
      if (k >= 1) checkOutput($sformatf("passthru_%0d", k), outPacked, hist[k-1]);
    end

    // White result, fade ramp observed through a backdrop pixel over black video.
    pulse(1'b1, 1'b0, 1'b0);
    checkPixel("fade_a0", 10, 10, 12'h000, 1'b0, 12'h000);
    checkPixel("fade_blank", 10, 10, 12'habc, 1'b1, 12'h000);
    frameTick();
    checkPixel("fade_a4", 10, 10, 12'h000, 1'b0, 12'h030);
    checkOutput("shown_a4", 38'(shown), 38'd0);
    frameTick();
    checkPixel("fade_a8", 10, 10, 12'h000, 1'b0, 12'h070);
    frameTick();
    checkPixel("fade_a12", 10, 10, 12'h000, 1'b0, 12'h0b0);
    checkOutput("shown_a12", 38'(shown), 38'd0);
    frameTick();
    checkOutput("shown_a16", 38'(shown), 38'd1);

    for (int i = 0; i < 16; i++) begin
      checkPixel(vecs[i].name, vecs[i].h, vecs[i].v, vecs[i].rgb, vecs[i].blank, vecs[i].exp);
    end

    pulse(1'b0, 1'b0, 1'b1);
    checkOutput("newgame_shown", 38'(shown), 38'd0);
    checkPixel("newgame_pass", 500, 400, 12'h5a3, 1'b0, 12'h5a3);

    // Black result at alpha 8.
    pulse(1'b0, 1'b1, 1'b0);
    frameTick();
    frameTick();
    checkPixel("b_outside", 10, 10, 12'h0f0, 1'b0, 12'h0f0);
    checkPixel("b_outline", 272, 188, 12'h444, 1'b0, 12'h555);
    checkPixel("b_fill", 500, 400, 12'h444, 1'b0, 12'h222);

    // new_game mid-fade: one more overlaid pixel, then pass-through.
    newGame = 1'b1;
    @(negedge clk);
    checkOutput("ng_last_overlay", 38'(rgbOut), 38'(12'h222));
    newGame = 1'b0;
    rgbIn   = 12'h9c1;
    @(negedge clk);
    checkOutput("ng_pass_old", 38'(rgbOut), 38'(12'h444));
    @(negedge clk);
    checkOutput("ng_pass_new", 38'(rgbOut), 38'(12'h9c1));
    checkOutput("ng_shown", 38'(shown), 38'd0);

    // new_game beats a simultaneous win.
    pulse(1'b1, 1'b1, 1'b1);
    checkPixel("ng_win_blank_pass", 10, 10, 12'habc, 1'b1, 12'habc);
    frameTick();
    checkPixel("ng_win_no_fade", 10, 10, 12'h000, 1'b0, 12'h000);

    // Draw result, then a late white_win must not change anything.
    pulse(1'b1, 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) frameTick();
    checkOutput("draw_shown", 38'(shown), 38'd1);
    checkPixel("draw_fill", 500, 400, 12'h123, 1'b0, 12'h888);
    checkPixel("draw_accent", 464, 212, 12'h000, 1'b0, 12'h666);
    pulse(1'b1, 1'b0, 1'b0);
    checkPixel("draw_fill_late_w", 500, 400, 12'h123, 1'b0, 12'h888);
    checkOutput("draw_shown_late_w", 38'(shown), 38'd1);

    // Reset in the middle of a fade.
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    frameTick();
    checkPixel("rst_fade_a4", 10, 10, 12'h000, 1'b0, 12'h030);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_out", outPacked, 38'd0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mid_pass", 38'(rgbOut), 38'(12'h000));
    checkOutput("rst_mid_shown", 38'(shown), 38'd0);
    checkPixel("rst_mid_blank_pass", 10, 10, 12'h7e2, 1'b1, 12'h7e2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1500000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", testsRun);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
